// File: rtl/bram_sdp_be.sv
`default_nettype none
// ============================================================================
// Module      : bram_sdp_be
// Description : Simple dual-port block RAM with per-byte write enables.
//               Port A writes, port B reads. The read latency is 1 + out_reg.
//               The same-address read-during-write result is selected by
//               rdw_mode. A two-state controller (INIT/RUN) gates all port
//               activity.
//               Optional macro BRAM_INIT_CLEAR_EN: when it is defined, INIT
//               zero-fills the whole array, one word per cycle. When it is
//               undefined, INIT lasts a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_sdp_be #(
   parameter int data_width = 32,
   parameter int addr_width = 11,
   parameter int out_reg    = 0,
   parameter int rdw_mode   = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      ready,
   input  logic                      wea,
   input  logic [addr_width-1:0]     addra,
   input  logic [data_width-1:0]     dina,
   input  logic [data_width/8-1:0]   bea,
   input  logic                      reb,
   input  logic [addr_width-1:0]     addrb,
   output logic [data_width-1:0]     doutb,
   output logic                      validb
);

   localparam int c_nbytes = data_width / 8;
   localparam int c_depth  = 2 ** addr_width;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                  r_state;
   logic                    r_ready;
   logic [data_width-1:0]   r_mem [c_depth];

   logic                    w_run;
   logic                    w_user_we;
   logic                    w_rd;
   logic                    w_wr_en;
   logic [addr_width-1:0]   w_wr_addr;
   logic [data_width-1:0]   w_wr_data;
   logic [c_nbytes-1:0]     w_wr_be;
   logic [data_width-1:0]   w_rd_word;

   logic                    r_v1;
   logic [data_width-1:0]   r_d1;

`ifdef BRAM_INIT_CLEAR_EN
   logic [addr_width-1:0]   r_init_cnt;
`endif

   // A cycle carrying rst never acts on the ports, even when the controller is still in RUN.
   assign w_run     = (r_state == ST_RUN) && !rst;
   assign w_user_we = w_run && wea;
   assign w_rd      = w_run && reb;
   assign ready     = r_ready;

   // Controller: INIT after reset, then RUN. ready is registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_INIT;
         r_ready    <= 1'b0;
`ifdef BRAM_INIT_CLEAR_EN
         r_init_cnt <= '0;
`endif
      end else begin
         case (r_state)
            ST_INIT: begin
`ifdef BRAM_INIT_CLEAR_EN
               r_init_cnt <= r_init_cnt + 1'b1;
               if (r_init_cnt == {addr_width{1'b1}}) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end
`else
               r_state <= ST_RUN;
               r_ready <= 1'b1;
`endif
            end
            ST_RUN: begin
               r_state <= ST_RUN;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= ST_INIT;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   // Write-port mux: the user write in RUN, or the zero-fill sweep during INIT.
   always_comb begin
      w_wr_en   = w_user_we;
      w_wr_addr = addra;
      w_wr_data = dina;
      w_wr_be   = bea;
`ifdef BRAM_INIT_CLEAR_EN
      if ((r_state == ST_INIT) && !rst) begin
         w_wr_en   = 1'b1;
         w_wr_addr = r_init_cnt;
         w_wr_data = '0;
         w_wr_be   = '1;
      end
`endif
   end

   // Memory array: only the byte lanes selected by w_wr_be are updated. There is no reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < c_nbytes; i++) begin
            if (w_wr_be[i]) begin
               r_mem[w_wr_addr][8*i +: 8] <= w_wr_data[8*i +: 8];
            end
         end
      end
   end

   generate
      if (rdw_mode == 1) begin : g_write_first
         // Write-first: on a same-address write, the enabled lanes are forwarded from dina.
         always_comb begin
            w_rd_word = r_mem[addrb];
            if (w_user_we && (addra == addrb)) begin
               for (int i = 0; i < c_nbytes; i++) begin
                  if (bea[i]) begin
                     w_rd_word[8*i +: 8] = dina[8*i +: 8];
                  end
               end
            end
         end
      end else begin : g_read_first
         // Read-first: the array read sees the pre-edge contents.
         assign w_rd_word = r_mem[addrb];
      end
   endgenerate

   // First read stage: the data register is loaded only on a read, so it holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_d1 <= '0;
      end else begin
         r_v1 <= w_rd;
         if (w_rd) begin
            r_d1 <= w_rd_word;
         end
      end
   end

   generate
      if (out_reg == 1) begin : g_out_reg
         logic                  r_v2;
         logic [data_width-1:0] r_d2;
         // Optional output stage: it forwards only completed reads and holds otherwise.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_v2 <= 1'b0;
               r_d2 <= '0;
            end else begin
               r_v2 <= r_v1;
               if (r_v1) begin
                  r_d2 <= r_d1;
               end
            end
         end
         assign validb = r_v2;
         assign doutb  = r_d2;
      end else begin : g_no_out_reg
         assign validb = r_v1;
         assign doutb  = r_d1;
      end
   endgenerate

endmodule
`default_nettype wire
